apu_fpu_credit_wrapper: RTL and testbench

Credit-based successor to the APU-side FP wrapper: sits between the core's APU master port and an external FP unit (fpnew_top instance) with variable latency. Unlike the previous wrapper, it honours apu_rready_i backpressure via a response FIFO of RESP_DEPTH entries. Issue credits guarantee that no FP-unit result is ever dropped.

---
 rtl/apu_fpu_credit_wrapper.sv | 116 +++++++++++
 tb/tb_apu_fpu_credit_wrapper.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_fpu_credit_wrapper.sv
// apu_fpu_credit_wrapper: credit-gated bridge from the APU master port to a variable-latency FP unit.
// Define APU_STICKY_FLAGS_EN to accumulate the status flags of every returned response.
module apu_fpu_credit_wrapper #(
    parameter int ID_WIDTH        = 9,
    parameter int NB_ARGS         = 3,
    parameter int DATA_WIDTH      = 32,
    parameter int OPCODE_WIDTH    = 6,
    parameter int FLAGS_IN_WIDTH  = 15,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int RESP_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          apu_req_i,
    output logic                          apu_gnt_o,
    input  logic [ID_WIDTH-1:0]           apu_ID_i,
    input  logic [NB_ARGS*DATA_WIDTH-1:0] apu_operands_i,
    input  logic [OPCODE_WIDTH-1:0]       apu_op_i,
    input  logic [FLAGS_IN_WIDTH-1:0]     apu_flags_i,
    input  logic                          apu_rready_i,
    output logic                          apu_rvalid_o,
    output logic [DATA_WIDTH-1:0]         apu_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0]    apu_rflags_o,
    output logic [ID_WIDTH-1:0]           apu_rID_o,
    output logic                          fpu_in_valid_o,
    input  logic                          fpu_in_ready_i,
    output logic [NB_ARGS*DATA_WIDTH-1:0] fpu_operands_o,
    output logic [OPCODE_WIDTH-1:0]       fpu_op_o,
    output logic [FLAGS_IN_WIDTH-1:0]     fpu_flags_o,
    output logic [ID_WIDTH-1:0]           fpu_tag_o,
    input  logic                          fpu_out_valid_i,
    output logic                          fpu_out_ready_o,
    input  logic [DATA_WIDTH-1:0]         fpu_result_i,
    input  logic [FLAGS_OUT_WIDTH-1:0]    fpu_status_i,
    input  logic [ID_WIDTH-1:0]           fpu_tag_i,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [FLAGS_OUT_WIDTH-1:0]    apu_sticky_flags_o,
    input  logic                          sticky_clr_i
);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int EW = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_fill;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [EW-1:0] r_mem [RESP_DEPTH];
    logic          r_err;
    logic          w_can_issue;
    logic          w_fire;
    logic          w_pop;
    logic          w_push;
    logic          w_idle;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A credit covers an op from issue until its response is popped, so the FIFO can never overflow.
    assign w_can_issue     = rst_n & (r_cnt < CW'(RESP_DEPTH));
    assign fpu_in_valid_o  = apu_req_i & w_can_issue;
    assign apu_gnt_o       = fpu_in_ready_i & w_can_issue;
    assign w_fire          = apu_req_i & apu_gnt_o;
    assign fpu_operands_o  = apu_operands_i;
    assign fpu_op_o        = apu_op_i;
    assign fpu_flags_o     = apu_flags_i;
    assign fpu_tag_o       = apu_ID_i;
    assign fpu_out_ready_o = 1'b1;

    assign w_idle       = (r_cnt == r_fill);
    assign w_push       = fpu_out_valid_i & ~w_idle;
    assign apu_rvalid_o = (r_fill != '0);
    assign w_pop        = apu_rvalid_o & apu_rready_i;
    assign {apu_rdata_o, apu_rflags_o, apu_rID_o} = apu_rvalid_o ? r_mem[r_rd_ptr] : '0;
    assign busy_o       = (r_cnt != '0);
    assign err_o        = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_fill   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + CW'(w_fire) - CW'(w_pop);
            r_fill <= r_fill + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wr_ptr <= f_inc(r_wr_ptr);
            if (w_pop) r_rd_ptr <= f_inc(r_rd_ptr);
            if (fpu_out_valid_i & w_idle) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {fpu_result_i, fpu_status_i, fpu_tag_i};
    end

`ifdef APU_STICKY_FLAGS_EN
    logic [FLAGS_OUT_WIDTH-1:0] r_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sticky <= '0;
        else if (sticky_clr_i) r_sticky <= '0;
        else if (w_pop) r_sticky <= r_sticky | apu_rflags_o;
    end

    assign apu_sticky_flags_o = r_sticky;
`else
    logic w_unused_clr;

    assign w_unused_clr       = sticky_clr_i;
    assign apu_sticky_flags_o = '0;
`endif
endmodule

// File: tb/tb_apu_fpu_credit_wrapper.sv
// tb_apu_fpu_credit_wrapper: fixed-latency FP-unit model plus response scoreboard for the credit wrapper.
module tb_apu_fpu_credit_wrapper;
    localparam int D = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        apu_req_i, apu_gnt_o, apu_rready_i, apu_rvalid_o;
    logic [8:0]  apu_ID_i, apu_rID_o, fpu_tag_o, fpu_tag_i;
    logic [95:0] apu_operands_i, fpu_operands_o;
    logic [5:0]  apu_op_i, fpu_op_o;
    logic [14:0] apu_flags_i, fpu_flags_o;
    logic [31:0] apu_rdata_o, fpu_result_i;
    logic [4:0]  apu_rflags_o, fpu_status_i, apu_sticky_flags_o;
    logic        fpu_in_valid_o, fpu_in_ready_i, fpu_out_valid_i, fpu_out_ready_o;
    logic        busy_o, err_o, sticky_clr_i;

    always #5 clk = ~clk;

    apu_fpu_credit_wrapper #(.RESP_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o), .apu_ID_i(apu_ID_i),
        .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i), .apu_flags_i(apu_flags_i),
        .apu_rready_i(apu_rready_i), .apu_rvalid_o(apu_rvalid_o), .apu_rdata_o(apu_rdata_o),
        .apu_rflags_o(apu_rflags_o), .apu_rID_o(apu_rID_o),
        .fpu_in_valid_o(fpu_in_valid_o), .fpu_in_ready_i(fpu_in_ready_i),
        .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
        .fpu_tag_o(fpu_tag_o), .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .busy_o(busy_o), .err_o(err_o), .apu_sticky_flags_o(apu_sticky_flags_o),
        .sticky_clr_i(sticky_clr_i)
    );

    typedef struct packed {
        logic [8:0]  tag;
        logic [31:0] res;
        logic [4:0]  st;
        logic [31:0] due;
    } op_t;

    op_t         fq[$];
    op_t         sb[$];
    int          cyc, n_chk, n_err, cnt_m, grants;
    logic        err_m;
    logic [4:0]  sticky_m, last_sticky;
    logic        s_rst, s_req, s_rready, s_clr, s_inject;
    logic [8:0]  s_id, last_rid;
    logic [95:0] s_ops;
    logic        last_gnt, last_rvalid, last_busy, last_err, last_fov;
    logic [31:0] last_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fp_res(input logic [95:0] o, input logic [8:0] t);
        return (o[31:0] == 32'h3F80_0000 && o[63:32] == 32'h4000_0000) ? 32'h4040_0000
                                                                      : o[31:0] ^ o[63:32] ^ {23'd0, t};
    endfunction

    task automatic step();
        op_t e, p;
        logic fire, pop, dlv, inj;
        int fifo_m;
        @(negedge clk);
        rst_n = ~s_rst;
        apu_req_i = s_req;
        apu_ID_i = s_id;
        apu_operands_i = s_ops;
        apu_op_i = s_id[5:0];
        apu_flags_i = {6'd0, s_id};
        apu_rready_i = s_rready;
        sticky_clr_i = s_clr;
        fpu_in_ready_i = 1'b1;
        fpu_out_valid_i = 1'b0;
        fpu_result_i = '0;
        fpu_status_i = '0;
        fpu_tag_i = '0;
        dlv = 1'b0;
        inj = 1'b0;
        if (s_rst) begin
            fq.delete();
            sb.delete();
            cnt_m = 0;
            err_m = 1'b0;
            sticky_m = '0;
        end else if (fq.size() > 0 && fq[0].due <= cyc) begin
            e = fq.pop_front();
            dlv = 1'b1;
            fpu_out_valid_i = 1'b1;
            fpu_result_i = e.res;
            fpu_status_i = e.st;
            fpu_tag_i = e.tag;
        end else if (s_inject && fq.size() == 0) begin
            inj = 1'b1;
            fpu_out_valid_i = 1'b1;
            fpu_result_i = 32'hDEAD_BEEF;
            fpu_status_i = 5'h1F;
            fpu_tag_i = 9'h155;
        end
        #1;
        if (s_rst) begin
            chk("rst_gnt", apu_gnt_o, 0);
            chk("rst_in_valid", fpu_in_valid_o, 0);
            chk("rst_rvalid", apu_rvalid_o, 0);
            chk("rst_rdata", apu_rdata_o, 0);
            chk("rst_rid", apu_rID_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_sticky", apu_sticky_flags_o, 0);
            chk("rst_out_ready", fpu_out_ready_o, 1);
        end else begin
            fifo_m = sb.size() - fq.size() - int'(dlv);
            chk("gnt", apu_gnt_o, cnt_m < D);
            chk("in_valid", fpu_in_valid_o, s_req && cnt_m < D);
            chk("rvalid", apu_rvalid_o, fifo_m != 0);
            chk("busy", busy_o, cnt_m != 0);
            chk("err", err_o, err_m);
            chk("sticky", apu_sticky_flags_o, sticky_m);
            fire = apu_req_i & apu_gnt_o;
            pop = apu_rvalid_o & apu_rready_i;
            if (fire) begin
                chk("fpu_tag", fpu_tag_o, s_id);
                chk("fpu_ops", fpu_operands_o, s_ops);
                e.tag = s_id;
                e.res = fp_res(s_ops, s_id);
                e.st = s_id[4:0];
                e.due = cyc + 2;
                fq.push_back(e);
                sb.push_back(e);
                grants++;
            end
            if (pop) begin
                if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
                else begin
                    p = sb.pop_front();
                    chk("rID", apu_rID_o, p.tag);
                    chk("rdata", apu_rdata_o, p.res);
                    chk("rflags", apu_rflags_o, p.st);
`ifdef APU_STICKY_FLAGS_EN
                    if (!s_clr) sticky_m = sticky_m | p.st;
`endif
                end
            end
            if (s_clr) sticky_m = '0;
            if (inj) err_m = 1'b1;
            cnt_m = cnt_m + int'(fire) - int'(pop);
            if (fire) begin
                s_id = s_id + 9'd1;
                s_ops = {$urandom(), $urandom(), $urandom()};
            end
        end
        last_gnt = apu_gnt_o;
        last_rvalid = apu_rvalid_o;
        last_rdata = apu_rdata_o;
        last_rid = apu_rID_o;
        last_busy = busy_o;
        last_err = err_o;
        last_fov = fpu_out_valid_i;
        last_sticky = apu_sticky_flags_o;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        {apu_req_i, apu_ID_i, apu_operands_i, apu_op_i, apu_flags_i, apu_rready_i} = '0;
        {fpu_in_ready_i, fpu_out_valid_i, fpu_result_i, fpu_status_i, fpu_tag_i, sticky_clr_i} = '0;
        {s_req, s_rready, s_clr, s_inject, s_id, s_ops} = '0;
        s_rst = 1'b1;
        {cyc, n_chk, n_err, cnt_m, grants} = '0;
        err_m = 1'b0;
        sticky_m = '0;
        repeat (3) step();
        s_rst = 1'b0;
        step();
        // single op: issue, FP result two cycles later, response the cycle after
        s_id = 9'h1A;
        s_ops = {32'h0, 32'h4000_0000, 32'h3F80_0000};
        s_req = 1'b1;
        s_rready = 1'b1;
        step();
        chk("t1_gnt", last_gnt, 1);
        s_req = 1'b0;
        step();
        step();
        chk("t1_fpu_out_valid", last_fov, 1);
        chk("t1_rvalid_early", last_rvalid, 0);
        step();
        chk("t1_rvalid", last_rvalid, 1);
        chk("t1_rdata", last_rdata, 32'h4040_0000);
        chk("t1_rid", last_rid, 9'h1A);
        step();
        chk("t1_busy_after_pop", last_busy, 0);
        // credit exhaustion with backpressure, then pop without same-cycle bypass
        s_rready = 1'b0;
        s_req = 1'b1;
        grants = 0;
        repeat (6) step();
        chk("t2_grants", grants, D);
        chk("t2_gnt_off", last_gnt, 0);
        chk("t2_busy_full", last_busy, 1);
        s_rready = 1'b1;
        step();
        chk("t3_pop_rvalid", last_rvalid, 1);
        chk("t3_no_bypass", last_gnt, 0);
        step();
        chk("t3_gnt_next", last_gnt, 1);
        s_req = 1'b0;
        repeat (20) step();
        chk("t2_drained", sb.size(), 0);
        // pointer wrap with rready toggling every cycle
        grants = 0;
        s_req = 1'b1;
        for (int i = 0; i < 400 && grants < 10; i++) begin
            s_rready = i[0];
            step();
        end
        chk("wrap_grants", grants, 10);
        s_req = 1'b0;
        s_rready = 1'b1;
        repeat (20) step();
        chk("wrap_drained", sb.size(), 0);
        // sticky flag accumulation and clear
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        s_id = 9'h01;
        s_req = 1'b1;
        step();
        s_req = 1'b0;
        repeat (8) step();
        s_id = 9'h10;
        s_req = 1'b1;
        step();
        s_req = 1'b0;
        repeat (8) step();
`ifdef APU_STICKY_FLAGS_EN
        chk("sticky_acc", last_sticky, 5'h11);
`else
        chk("sticky_off", last_sticky, 5'h00);
`endif
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        step();
        chk("sticky_clr", last_sticky, 5'h00);
        // protocol error: result with nothing in flight
        s_inject = 1'b1;
        step();
        s_inject = 1'b0;
        step();
        chk("err_set", last_err, 1);
        chk("err_fifo_empty", last_rvalid, 0);
        repeat (3) step();
        chk("err_holds", last_err, 1);
        // reset in the middle of traffic
        s_req = 1'b1;
        s_rready = 1'b0;
        repeat (2) step();
        s_req = 1'b0;
        step();
        s_rst = 1'b1;
        repeat (2) step();
        s_rst = 1'b0;
        s_rready = 1'b1;
        step();
        chk("rst_err_cleared", last_err, 0);
        chk("rst_busy_cleared", last_busy, 0);
        s_req = 1'b1;
        step();
        s_req = 1'b0;
        repeat (8) step();
        chk("post_rst_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
